// File: rtl/conv_window_sched.sv
// Window sequencer for the 1-D convolution datapath.
// Walks all N-M+1 windows and hands each result to a one-deep output register.
module conv_window_sched #(
    parameter int N   = 128,
    parameter int M   = 32,
    parameter int T   = 8,
    parameter int XAW = $clog2(N),
    parameter int FAW = $clog2(M)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           x_full,
    output logic [XAW-1:0] xmem_addr,
    output logic [FAW-1:0] fmem_addr,
    output logic           mac_clr,
    output logic           mult_en,
    output logic           acc_en,
    input  logic [T-1:0]   accum_data,
    output logic           m_valid_y,
    input  logic           m_ready_y,
    output logic [T-1:0]   m_data_out_y,
    output logic           conv_done,
    output logic           busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_CAPT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [XAW:0]   LAST_BASE = (XAW+1)'(N - M);
    localparam logic [FAW-1:0] K_LAST    = FAW'(M - 1);

    logic [2:0]     state;
    logic [XAW:0]   base;
    logic [FAW-1:0] k;
    logic [1:0]     dcnt;
    logic           rd_vld;
    logic           accept;
    logic           xfer;
    logic [XAW:0]   addr_sum;

    assign rd_vld   = (state == S_ISSUE);
    assign xfer     = m_valid_y && m_ready_y;
    assign accept   = (state == S_CAPT) && (!m_valid_y || m_ready_y);
    assign addr_sum = base + {{(XAW+1-FAW){1'b0}}, k};

    assign xmem_addr = rd_vld ? addr_sum[XAW-1:0] : '0;
    assign fmem_addr = rd_vld ? k : '0;
    assign busy      = (state != S_IDLE);

    // Gated by reset so a high x_full cannot clear the MAC while held in reset.
    assign mac_clr = reset_n &&
                     (((state == S_IDLE) && x_full) || accept);

    // Enables trail the address by the memory read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mult_en <= 1'b0;
            acc_en  <= 1'b0;
        end else begin
            mult_en <= rd_vld;
            acc_en  <= mult_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            base      <= '0;
            k         <= '0;
            dcnt      <= '0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            unique case (1'b1)
                state == S_IDLE: begin
                    if (x_full) begin
                        base  <= '0;
                        k     <= '0;
                        state <= S_ISSUE;
                    end
                end
                state == S_ISSUE: begin
                    k <= k + 1'b1;
                    if (k == K_LAST) begin
                        k     <= '0;
                        dcnt  <= '0;
                        state <= S_DRAIN;
                    end
                end
                state == S_DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == 2'd2)
                        state <= S_CAPT;
                end
                state == S_CAPT: begin
                    if (accept) begin
                        if (base == LAST_BASE) begin
                            state <= S_FINISH;
                        end else begin
                            base  <= base + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                state == S_FINISH: begin
                    if (xfer) begin
                        conv_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reload in CAPT wins over the drain from a same-cycle transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
        end else if (accept) begin
            m_valid_y    <= 1'b1;
            m_data_out_y <= accum_data;
        end else if (xfer) begin
            m_valid_y    <= 1'b0;
        end
    end

endmodule
